lb_fifo: RTL and testbench
==========================

# lb_fifo

Parametrised show-ahead FIFO that succeeds the single-entry `lb_buffer` between the PicoBlaze I/O port logic and the UART TX/RX engines. It adds configurable data width and depth (power of two), an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags readable by firmware. Port names and read/write semantics match `lb_buffer`, so existing instantiations remain valid with default parameters plus the added outputs left open.

## Interface
- `DATA_W`, 8: width of `w_data`/`r_data`.
- `ADDR_W`, 4: pointer width; depth `DEPTH = 2**ADDR_W`, legal range 1..8.
- `AF_LEVEL`, `DEPTH-2`: `almost_full` asserts when `count >= AF_LEVEL`; legal range 1..DEPTH.
- `AE_LEVEL`, 2: `almost_empty` asserts when `count <= AE_LEVEL`; legal range 0..DEPTH-1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `clr` in 1: synchronous flush; empties the FIFO and clears the error flags.
- `we` in 1: write strobe; pushes `w_data` on the clock edge.
- `w_data` in DATA_W: write data.
- `re` in 1: read/pop strobe; advances the head on the clock edge.
- `r_data` out DATA_W: head entry, valid whenever `empty`=0 (show-ahead).
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `almost_full` out 1: `count >= AF_LEVEL`.
- `almost_empty` out 1: `count <= AE_LEVEL`.
- `count` out ADDR_W+1: number of stored entries, 0..DEPTH.
- `overflow` out 1: sticky; set by a write that is dropped.
- `underflow` out 1: sticky; set by a read that is dropped.

## Operation
- Storage is a DEPTH x DATA_W register array with `wr_ptr` and `rd_ptr` (ADDR_W bits each), which wrap modulo DEPTH, and a `count` register. `full`, `empty`, and the almost flags are decoded combinationally from `count`.
- Push: occurs when `we`=1 and (`full`=0 or `re`=1). The data is written to `mem[wr_ptr]` and `wr_ptr` increments.
- Pop: occurs when `re`=1 and `empty`=0. `rd_ptr` increments.
- `count` update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous `we` and `re`:
  - When full, both the push and the pop occur; `count` stays at DEPTH.
  - When empty, the push occurs and the pop is dropped, so `underflow` sets and `count` becomes 1.
- A write with `we`=1, `full`=1, `re`=0 is dropped, `overflow` sets, and the contents are unchanged.
- A read with `re`=1 and `empty`=1 is dropped and sets `underflow`.
- `r_data` = `mem[rd_ptr]`, combinational from the pointer and array. Its value is unspecified while `empty`=1, except after reset, when it is 0.
- `clr` has priority over `we`/`re` in the same cycle. It zeroes the pointers, `count`, `overflow`, and `underflow`; array contents are kept.
- `reset` zeroes the pointers, `count`, both error flags, and every array entry.

## Timing
- Reset values: `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0 (for AF_LEVEL>=1), `count`=0, `r_data`=0, `overflow`=0, `underflow`=0.
- Reset takes effect immediately on assertion, independent of `clk`, and is released synchronously by the design above this block.
- Write-to-read latency: data written at edge N appears on `r_data` and `empty` falls right after edge N (one cycle from `we` sampled to data visible).
- After a pop at edge N, the next entry is on `r_data` after edge N.
- Flags and `count` change only after clock edges, never combinationally from `we`/`re`.
- Error flags set after the offending edge and hold until `clr` or `reset`.
- Throughput: one push and one pop per cycle sustained, at any fill level.

## Test plan
- Reset: assert `reset` mid-stream with 3 entries stored -> outputs go to their reset values without a clock edge; after release, `r_data`=0 and `empty`=1.
- Fill/drain (ADDR_W=2, AF_LEVEL=3, AE_LEVEL=1): write A5, AA, FE, 5A on consecutive cycles -> `count` 1,2,3,4; `almost_empty` falls at count 2; `almost_full` rises at 3; `full` at 4. Four pops -> `r_data` A5, AA, FE, 5A in order; `empty`=1.
- Overflow: with the FIFO full, write 77 with `re`=0 -> `overflow`=1, contents unchanged, drain yields the original four bytes. A later `clr` -> `overflow`=0, `count`=0.
- Simultaneous access when full: `we`=1 (data 11) and `re`=1 -> head advances, `count` stays 4, 11 is read last. When empty: `we`=1 (data 22) and `re`=1 -> `count`=1, `r_data`=22, `underflow`=1.
- Wrap-around: 10 pushes interleaved with pops (data 01..0A) across the pointer wrap -> output sequence 01..0A with no loss and `count` consistent every cycle.
- Flush priority: `clr`, `we`, and `re` all asserted at count 3 -> `count`=0 and `empty`=1 on the next cycle; the written byte is not stored.

Source files
------------

// File: rtl/lb_fifo.sv
// Show-ahead FIFO for the PicoBlaze UART path: parametrised width/depth, occupancy
// count, almost flags, synchronous flush and sticky overflow/underflow flags.
module lb_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = (2 ** ADDR_W) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [DATA_W-1:0] w_data,
  input  logic              re,
  output logic [DATA_W-1:0] r_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_C    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   AE_C    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push, pop;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign r_data       = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the same edge pops the head.
  assign push = we && (!full || re);
  assign pop  = re && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (we && !push) ovf_d = 1'b1;
      if (re && !pop)  unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Array is cleared on reset so r_data reads 0 straight out of reset; flush keeps contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!clr && push) begin
      mem_q[wr_ptr_q] <= w_data;
    end
  end

endmodule

// File: tb/tb_lb_fifo.sv
// Scoreboard bench for lb_fifo with a 4-entry configuration (AF_LEVEL=3, AE_LEVEL=1).
module tb_lb_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic       we = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       re = 1'b0;
  logic [7:0] r_data;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  lb_fifo #(.DATA_W(8), .ADDR_W(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .w_data(w_data), .re(re),
    .r_data(r_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Drives one cycle, updates the reference queue, returns the expected and observed head on a pop.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c,
                      output logic popped, output logic [7:0] exp_v, output logic [7:0] act_v);
    int n;
    n = sb.size();
    popped = 1'b0;
    exp_v = 8'h00;
    act_v = r_data;
    we = w; w_data = d; re = r; clr = c;
    if (c) begin
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (r && n != 0) begin
        popped = 1'b1;
        exp_v = sb.pop_front();
      end
      if (w && (n != DEPTH || r)) sb.push_back(d);
      if (w && n == DEPTH && !r) m_ovf = 1'b1;
      if (r && n == 0) m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    logic p; logic [7:0] ev, av;
    checks++;
    if ({count, empty, full, almost_empty, almost_full, r_data, overflow, underflow} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_init: cnt=%0d e=%b f=%b ae=%b af=%b rd=%h ov=%b un=%b, need 0 1 0 1 0 00 0 0",
               count, empty, full, almost_empty, almost_full, r_data, overflow, underflow);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, p, ev, av);
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL reset_unf_set: got %b need 1", underflow); end
    step(1'b1, 8'h3C, 1'b0, 1'b0, p, ev, av);
    step(1'b1, 8'h3D, 1'b0, 1'b0, p, ev, av);
    step(1'b1, 8'h3E, 1'b0, 1'b0, p, ev, av);
    checks++;
    if (count !== 3'd3 || r_data !== 8'h3C) begin
      errors++; $display("FAIL reset_prefill: cnt=%0d rd=%h need 3 3c", count, r_data);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({count, empty, full, almost_empty, almost_full, r_data, overflow, underflow} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: cnt=%0d e=%b f=%b ae=%b af=%b rd=%h ov=%b un=%b, need 0 1 0 1 0 00 0 0",
               count, empty, full, almost_empty, almost_full, r_data, overflow, underflow);
    end
    sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (r_data !== 8'h00 || empty !== 1'b1) begin
      errors++; $display("FAIL reset_release: rd=%h e=%b need 00 1", r_data, empty);
    end
  endtask

  task automatic test_fill_drain();
    logic p; logic [7:0] ev, av;
    logic [7:0] pat [4] = '{8'hA5, 8'hAA, 8'hFE, 8'h5A};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pat[i], 1'b0, 1'b0, p, ev, av);
      checks++;
      if (count !== 3'(sb.size()) || almost_empty !== (sb.size() <= 1) ||
          almost_full !== (sb.size() >= 3) || full !== (sb.size() == DEPTH) || empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d: cnt=%0d ae=%b af=%b f=%b e=%b, need cnt=%0d", i, count,
                 almost_empty, almost_full, full, empty, sb.size());
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, p, ev, av);
      checks++;
      if (!p || av !== ev) begin errors++; $display("FAIL drain_%0d: got %h need %h", i, av, ev); end
    end
    checks++;
    if (empty !== 1'b1 || count !== 3'd0 || almost_empty !== 1'b1) begin
      errors++; $display("FAIL drain_empty: e=%b cnt=%0d ae=%b need 1 0 1", empty, count, almost_empty);
    end
  endtask

  task automatic test_overflow();
    logic p; logic [7:0] ev, av;
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0, p, ev, av);
    step(1'b1, 8'h77, 1'b0, 1'b0, p, ev, av);
    checks++;
    if (overflow !== m_ovf || m_ovf !== 1'b1 || count !== 3'd4 || r_data !== 8'hC1) begin
      errors++; $display("FAIL ovf_set: ov=%b cnt=%0d rd=%h need 1 4 c1", overflow, count, r_data);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, p, ev, av);
      checks++;
      if (!p || av !== ev) begin errors++; $display("FAIL ovf_drain_%0d: got %h need %h", i, av, ev); end
    end
    checks++;
    if (overflow !== 1'b1 || empty !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: ov=%b e=%b need 1 1", overflow, empty);
    end
    step(1'b1, 8'h12, 1'b0, 1'b0, p, ev, av);
    step(1'b0, 8'h00, 1'b0, 1'b1, p, ev, av);
    checks++;
    if (overflow !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL ovf_clr: ov=%b cnt=%0d e=%b need 0 0 1", overflow, count, empty);
    end
  endtask

  task automatic test_simultaneous();
    logic p; logic [7:0] ev, av;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0, p, ev, av);
    step(1'b1, 8'h11, 1'b1, 1'b0, p, ev, av);
    checks++;
    if (!p || av !== ev || count !== 3'd4 || r_data !== 8'h32 || overflow !== 1'b0) begin
      errors++; $display("FAIL simul_full: popped=%h need %h cnt=%0d rd=%h ov=%b", av, ev, count, r_data, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, p, ev, av);
      checks++;
      if (!p || av !== ev) begin errors++; $display("FAIL simul_drain_%0d: got %h need %h", i, av, ev); end
    end
    checks++;
    if (ev !== 8'h11) begin errors++; $display("FAIL simul_last: got %h need 11", ev); end
    step(1'b1, 8'h22, 1'b1, 1'b0, p, ev, av);
    checks++;
    if (count !== 3'd1 || r_data !== 8'h22 || underflow !== m_unf || m_unf !== 1'b1) begin
      errors++; $display("FAIL simul_empty: cnt=%0d rd=%h un=%b need 1 22 1", count, r_data, underflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, p, ev, av);
    checks++;
    if (underflow !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL simul_clr: un=%b e=%b need 0 1", underflow, empty);
    end
  endtask

  task automatic test_wrap();
    logic p; logic [7:0] ev, av;
    int pops = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'(i), (i % 3) != 1, 1'b0, p, ev, av);
      if (p) begin
        pops++;
        checks++;
        if (av !== ev) begin errors++; $display("FAIL wrap_pop_%0d: got %h need %h", i, av, ev); end
      end
      checks++;
      if (count !== 3'(sb.size())) begin errors++; $display("FAIL wrap_cnt_%0d: got %0d need %0d", i, count, sb.size()); end
    end
    for (int k = 0; k < 8 && sb.size() != 0; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, p, ev, av);
      pops++;
      checks++;
      if (av !== ev) begin errors++; $display("FAIL wrap_drain_%0d: got %h need %h", k, av, ev); end
    end
    checks++;
    if (pops != 10 || ev !== 8'h0A || empty !== 1'b1 || underflow !== 1'b0) begin
      errors++; $display("FAIL wrap_total: pops=%0d last=%h e=%b un=%b need 10 0a 1 0", pops, ev, empty, underflow);
    end
  endtask

  task automatic test_flush();
    logic p; logic [7:0] ev, av;
    for (int i = 0; i < 3; i++) step(1'b1, 8'hE1 + 8'(i), 1'b0, 1'b0, p, ev, av);
    step(1'b1, 8'h99, 1'b1, 1'b1, p, ev, av);
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || underflow !== 1'b0) begin
      errors++; $display("FAIL flush_prio: cnt=%0d e=%b un=%b need 0 1 0", count, empty, underflow);
    end
    step(1'b1, 8'h44, 1'b0, 1'b0, p, ev, av);
    step(1'b0, 8'h00, 1'b1, 1'b0, p, ev, av);
    checks++;
    if (!p || av !== ev || ev !== 8'h44 || empty !== 1'b1) begin
      errors++; $display("FAIL flush_after: got %h need 44 e=%b", av, empty);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, need completion");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b1;
    #10 reset = 1'b0;
  end

endmodule
